// File: rtl/boxhead_hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus master.
package boxhead_hpi_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } hpi_state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int HPI_CNT_W = 8;

    // A phase of n cycles loads n-1 so the counter reaching zero marks its last cycle.
    function automatic logic [HPI_CNT_W-1:0] cyc_load(input int unsigned n);
        return (n == 0) ? '0 : HPI_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/boxhead_hpi_ctrl_if.sv
// Avalon-MM slave port and OTG HPI pin bundle of the HPI controller.
interface boxhead_hpi_avl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        irq;

    modport master (output address, chipselect, read, write, writedata,
                    input  readdata, waitrequest, irq);
    modport slave  (input  address, chipselect, read, write, writedata,
                    output readdata, waitrequest, irq);
endinterface

interface boxhead_hpi_otg_if;
    logic [1:0]  otg_addr;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic        otg_rst_n;
    logic        otg_int;

    modport master (output otg_addr, otg_data_out, otg_data_oe, otg_cs_n,
                           otg_rd_n, otg_wr_n, otg_rst_n,
                    input  otg_data_in, otg_int);
    modport slave  (input  otg_addr, otg_data_out, otg_data_oe, otg_cs_n,
                           otg_rd_n, otg_wr_n, otg_rst_n,
                    output otg_data_in, otg_int);
endinterface

// File: rtl/boxhead_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module boxhead_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/boxhead_hpi_ctrl.sv
// Avalon-MM slave that turns each CPU access into one timed HPI cycle on the EZ-OTG pins.
module boxhead_hpi_ctrl
    import boxhead_hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2,
    parameter int unsigned RST_CYC     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    boxhead_hpi_avl_if.slave     avl,
    boxhead_hpi_otg_if.master    otg
);

    hpi_state_t           state_q, state_d;
    logic [HPI_CNT_W-1:0] cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [1:0]           addr_q, addr_d;
    logic [15:0]          wdat_q, wdat_d;
    logic [15:0]          rdat_q, rdat_d;
    logic                 cs_n_q, rd_n_q, wr_n_q, oe_q, rst_n_q;
    logic                 req;
    logic                 last;
    logic                 on_bus_d;
    logic                 unused_wdata_hi;

    assign req             = avl.chipselect & (avl.read | avl.write);
    assign last            = (cnt_q == '0);
    assign unused_wdata_hi = ^avl.writedata[31:16];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        unique case (state_q)
            BOOT: begin
                if (last) state_d = IDLE;
                else      cnt_d   = cnt_q - 1'b1;
            end
            IDLE: begin
                if (req) begin
                    wr_d   = avl.write;
                    addr_d = avl.address;
                    wdat_d = avl.writedata[15:0];
                    if (SETUP_CYC != 0) begin
                        state_d = SETUP;
                        cnt_d   = cyc_load(SETUP_CYC);
                    end else begin
                        state_d = STROBE;
                        cnt_d   = cyc_load(STROBE_CYC);
                    end
                end
            end
            SETUP: begin
                if (last) begin
                    state_d = STROBE;
                    cnt_d   = cyc_load(STROBE_CYC);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (last) begin
                    // Sample while rd_n is still low, on the edge that ends the strobe.
                    if (!wr_q) rdat_d = otg.otg_data_in;
                    if (HOLD_CYC != 0) begin
                        state_d = HOLD;
                        cnt_d   = cyc_load(HOLD_CYC);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (last) state_d = DONE;
                else      cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                if (RECOVER_CYC != 0) begin
                    state_d = RECOVER;
                    cnt_d   = cyc_load(RECOVER_CYC);
                end else begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                if (last) state_d = IDLE;
                else      cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = BOOT;
        endcase
    end

    assign on_bus_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);

    // Pin outputs are registered from the next state so they switch with the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            cnt_q   <= cyc_load(RST_CYC);
            wr_q    <= 1'b0;
            addr_q  <= HPI_DATA;
            wdat_q  <= '0;
            rdat_q  <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            rst_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            cs_n_q  <= ~on_bus_d;
            rd_n_q  <= ~((state_d == STROBE) && !wr_d);
            wr_n_q  <= ~((state_d == STROBE) && wr_d);
            oe_q    <= on_bus_d && wr_d;
            rst_n_q <= (state_d != BOOT);
        end
    end

    always_comb begin
        unique case (state_q)
            IDLE, RECOVER: avl.waitrequest = req;
            DONE:          avl.waitrequest = 1'b0;
            default:       avl.waitrequest = 1'b1;
        endcase
    end

    assign avl.readdata     = {16'h0000, rdat_q};
    assign otg.otg_addr     = addr_q;
    assign otg.otg_data_out = wdat_q;
    assign otg.otg_data_oe  = oe_q;
    assign otg.otg_cs_n     = cs_n_q;
    assign otg.otg_rd_n     = rd_n_q;
    assign otg.otg_wr_n     = wr_n_q;
    assign otg.otg_rst_n    = rst_n_q;

    boxhead_sync2 u_irq_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (otg.otg_int),
        .q_o    (avl.irq)
    );

endmodule

// File: doc/boxhead_hpi_ctrl.md
# boxhead_hpi_ctrl

Hardware HPI bus master for the CY7C67200 EZ-OTG chip, replacing software bit-banging of the OTG address, data and strobe lines through separate PIO peripherals. It sits in the SoC as an Avalon-MM slave. Each CPU read or write becomes exactly one timed HPI cycle on the OTG pins. The block also sequences the chip's reset after power-up and synchronizes the OTG interrupt.

## Interface
Parameters:
- SETUP_CYC, 1, cycles with cs_n low and address/data valid before the strobe (0..15).
- STROBE_CYC, 4, cycles with rd_n or wr_n low (1..15).
- HOLD_CYC, 1, cycles with the strobe released and cs_n/address/data held (0..15).
- RECOVER_CYC, 2, idle cycles with cs_n high between consecutive HPI cycles (0..15).
- RST_CYC, 16, cycles otg_rst_n is held low after reset_n deasserts (1..255).

Ports:
- clk, in, 1, system clock. Single clock domain.
- reset_n, in, 1, asynchronous active-low reset.
- address, in, 2, Avalon word address. Maps directly to HPI port: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- chipselect, in, 1, Avalon select.
- read, in, 1, Avalon read.
- write, in, 1, Avalon write.
- writedata, in, 32, Avalon write data. Bits 15:0 are used.
- readdata, out, 32, {16'b0, captured HPI data}.
- waitrequest, out, 1, Avalon stall.
- irq, out, 1, otg_int after a 2-flop synchronizer.
- otg_addr, out, 2, HPI address.
- otg_data_out, out, 16, HPI write data.
- otg_data_oe, out, 1, enables the top-level tristate driver.
- otg_data_in, in, 16, HPI bus sampled value.
- otg_cs_n, out, 1, chip select, active low.
- otg_rd_n, out, 1, read strobe, active low.
- otg_wr_n, out, 1, write strobe, active low.
- otg_rst_n, out, 1, chip reset, active low.
- otg_int, in, 1, chip interrupt, active high, asynchronous.

## Operation
- States: BOOT, IDLE, SETUP, STROBE, HOLD, DONE, RECOVER.
- A single 8-bit down-counter provides every state duration.
- BOOT:
  - Entered on reset. otg_rst_n is held low for RST_CYC cycles, then the FSM moves to IDLE with otg_rst_n=1.
  - Any request during BOOT is stalled with waitrequest=1.
- IDLE:
  - A request is chipselect & (read | write).
  - On a request, latch address, writedata[15:0] and direction, then go to SETUP.
  - If SETUP_CYC=0, go straight to STROBE.
  - If read and write are both high, the access is a write.
- SETUP:
  - cs_n=0, otg_addr valid, rd_n=wr_n=1.
  - otg_data_oe=1 for a write.
- STROBE:
  - rd_n=0 for a read, wr_n=0 for a write.
  - On the last STROBE cycle, a read registers otg_data_in into the capture register.
- HOLD:
  - Strobe released, cs_n=0, address held.
  - For a write, data and oe are held.
  - If HOLD_CYC=0, skip to DONE.
- DONE:
  - One cycle. cs_n=1, oe=0, waitrequest=0, and the Avalon transfer completes.
  - Next state is RECOVER, or IDLE if RECOVER_CYC=0.
- RECOVER:
  - cs_n=1.
  - A new request is stalled with waitrequest=1 and is accepted on return to IDLE.
- waitrequest = 1 in BOOT, SETUP, STROBE, HOLD, and in IDLE/RECOVER while a request is present. It is 0 otherwise.
- readdata:
  - Holds the last captured value until the next read capture.
  - Writes do not alter it.
- irq = otg_int delayed by 2 flops. It is level, not latched.

## Timing
- Reset values:
  - otg_cs_n=otg_rd_n=otg_wr_n=1, otg_rst_n=0, otg_data_oe=0.
  - otg_addr=0, otg_data_out=0, readdata=0, irq=0.
  - waitrequest=1, state BOOT.
- Accept cycle t0 (in IDLE). SETUP occupies t1..tS, STROBE the next P cycles, HOLD the next H cycles.
- DONE occurs at t(S+P+H+1). With defaults that is t7, and the next accept is no earlier than t10.
- Read capture happens at the clock edge ending the last STROBE cycle. readdata is valid in DONE.
- otg_rst_n rises RST_CYC cycles after reset_n deasserts.
- The first access can be accepted in the cycle after otg_rst_n rises.
- Reset asserted mid-cycle:
  - All strobes, cs_n and oe deassert immediately (asynchronously).
  - otg_rst_n goes low and BOOT reruns.
  - The pending Avalon transfer is dropped.
- Address, data and direction are latched. Changes on the Avalon inputs during a stall do not affect the in-flight HPI cycle.

## Structure
- Package boxhead_hpi_pkg contains:
  - State enum hpi_state_t.
  - HPI port constants HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3.
  - Counter width constant HPI_CNT_W=8.
- Sub-module boxhead_sync2: a 2-flop synchronizer with async active-low reset, used for otg_int.

## Test plan
- Reset release with RST_CYC=16 -> otg_rst_n low for 16 cycles. A write issued during BOOT stalls until otg_rst_n=1.
- Write writedata=0x1234ABCD to address 2 (defaults):
  - otg_addr=2, otg_data_out=0xABCD, oe=1.
  - cs_n low 6 cycles, wr_n low exactly 4 cycles starting at t2.
  - waitrequest low only at t7.
- Read from address 0 with otg_data_in=0x5A5A during STROBE -> readdata=0x00005A5A at t7, rd_n low for 4 cycles, oe=0 throughout.
- Back-to-back: a write then an immediately re-asserted read -> cs_n high for at least 3 cycles (DONE + 2 RECOVER), and the read is accepted at t10.
- SETUP_CYC=0, HOLD_CYC=0, RECOVER_CYC=0 -> strobe in t1..t4, DONE at t5, next accept at t6.
- reset_n asserted during STROBE of a write -> wr_n/cs_n high and oe=0 within the same cycle, otg_rst_n=0, and BOOT reruns.
